// File: rtl/i2c_target_wishbone_if.sv
// Wishbone register bus of the I2C target peripheral.
// The master drives the request, the slave returns data and ack.
interface i2c_target_wishbone_if;
   logic [4:0] adr_i;
   logic [7:0] dat_i;
   logic [7:0] dat_o;
   logic       we_i;
   logic       stb_i;
   logic       cyc_i;
   logic       ack_o;

   modport master (
      output adr_i, dat_i, we_i, stb_i, cyc_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  adr_i, dat_i, we_i, stb_i, cyc_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/i2c_target_wishbone.sv
// I2C target with Wishbone registers (CTRL, STATUS, TX, RX, OWN_ADDR).
// Optional: define I2C_TGT_GLITCH_FILTER_EN for 3-sample majority filters.
module i2c_target_wishbone #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
   parameter int         SYNC_STAGES   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   i2c_target_wishbone_if.slave wb,
   input  logic                 scl,
   inout  wire                  sda
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_DATA,
      S_RX_ACK, S_TX_DATA, S_TX_ACK, S_WAIT_STOP
   } state_t;

   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic       ph_q, ph_d;
   logic       oe_q, oe_d;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic       scl_s, sda_s, scl_p_q, sda_p_q;
   logic       scl_rise, scl_fall, start_ev, stop_ev;

   logic [1:0] ctrl_q;
   logic [7:0] tx_q, rx_q, dat_o_q;
   logic [6:0] own_q;
   logic       ack_q, rx_valid_q, tx_empty_q, addressed_q, rw_q;
   logic [3:0] stk_q;
   logic [7:0] status, rdata, load_v, rx_byte;
   logic       req, wr, rd, tx_wr, rx_rd, en, ack_en;
   logic       ev_addr, ev_rx, ev_ovr, ev_load, ev_mnack, ev_stop;

   assign sda = oe_q ? 1'b0 : 1'bz;

   // Synchronise the bus lines into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      end
   end

`ifdef I2C_TGT_GLITCH_FILTER_EN
   logic [2:0] scl_h_q, sda_h_q;

   // Keep the last three synchronised samples for majority voting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_h_q <= '1;
         sda_h_q <= '1;
      end else begin
         scl_h_q <= {scl_h_q[1:0], scl_sync_q[SYNC_STAGES-1]};
         sda_h_q <= {sda_h_q[1:0], sda_sync_q[SYNC_STAGES-1]};
      end
   end

   assign scl_s = (scl_h_q[0] & scl_h_q[1]) | (scl_h_q[0] & scl_h_q[2]) |
                  (scl_h_q[1] & scl_h_q[2]);
   assign sda_s = (sda_h_q[0] & sda_h_q[1]) | (sda_h_q[0] & sda_h_q[2]) |
                  (sda_h_q[1] & sda_h_q[2]);
`else
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

   // Previous line values for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_p_q <= 1'b1;
         sda_p_q <= 1'b1;
      end else begin
         scl_p_q <= scl_s;
         sda_p_q <= sda_s;
      end
   end

   assign scl_rise = scl_s & ~scl_p_q;
   assign scl_fall = ~scl_s & scl_p_q;
   assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
   assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;

   assign en     = ctrl_q[0];
   assign ack_en = ctrl_q[1];
   assign req    = wb.cyc_i & wb.stb_i & ~ack_q;
   assign wr     = req & wb.we_i;
   assign rd     = req & ~wb.we_i;
   assign tx_wr  = wr & (wb.adr_i == 5'h08);
   assign rx_rd  = rd & (wb.adr_i == 5'h0C);

   assign status = {stk_q, rw_q, addressed_q, tx_empty_q, rx_valid_q};

   // Bus protocol next-state, shifter and line drive
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      ph_d     = ph_q;
      oe_d     = oe_q;
      ev_addr  = 1'b0;
      ev_rx    = 1'b0;
      ev_ovr   = 1'b0;
      ev_load  = 1'b0;
      ev_mnack = 1'b0;
      ev_stop  = 1'b0;
      load_v   = tx_wr ? wb.dat_i : (tx_empty_q ? 8'hFF : tx_q);
      rx_byte  = {sh_q[6:0], sda_s};
      if (!en) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         ph_d    = 1'b0;
      end else if (stop_ev) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         ph_d    = 1'b0;
         ev_stop = 1'b1;
      end else if (start_ev) begin
         state_d = S_ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
         ph_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_ADDR: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (rx_byte[7:1] == own_q && ack_en) begin
                     state_d = S_ADDR_ACK;
                     ev_addr = 1'b1;
                     ph_d    = 1'b0;
                  end else begin
                     state_d = S_WAIT_STOP;
                  end
               end
            end
            S_ADDR_ACK: if (scl_fall) begin
               if (!ph_q) begin
                  oe_d = 1'b1;
                  ph_d = 1'b1;
               end else begin
                  ph_d  = 1'b0;
                  cnt_d = '0;
                  if (rw_q) begin
                     state_d = S_TX_DATA;
                     sh_d    = load_v;
                     ev_load = 1'b1;
                     oe_d    = ~load_v[7];
                  end else begin
                     state_d = S_RX_DATA;
                     oe_d    = 1'b0;
                  end
               end
            end
            S_RX_DATA: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (rx_valid_q && !rx_rd) begin
                     ev_ovr  = 1'b1;
                     state_d = S_WAIT_STOP;
                  end else begin
                     ev_rx   = 1'b1;
                     state_d = S_RX_ACK;
                     ph_d    = 1'b0;
                  end
               end
            end
            S_RX_ACK: if (scl_fall) begin
               if (!ph_q) begin
                  oe_d = 1'b1;
                  ph_d = 1'b1;
               end else begin
                  oe_d    = 1'b0;
                  ph_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = S_RX_DATA;
               end
            end
            S_TX_DATA: if (scl_fall) begin
               if (ph_q) begin
                  oe_d    = 1'b0;
                  ph_d    = 1'b0;
                  state_d = S_TX_ACK;
               end else begin
                  oe_d = ~sh_q[7];
               end
            end else if (scl_rise) begin
               sh_d  = {sh_q[6:0], 1'b0};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) ph_d = 1'b1;
            end
            S_TX_ACK: if (scl_rise) begin
               if (!sda_s) begin
                  state_d = S_TX_DATA;
                  sh_d    = load_v;
                  ev_load = 1'b1;
                  cnt_d   = '0;
                  ph_d    = 1'b0;
               end else begin
                  ev_mnack = 1'b1;
                  state_d  = S_WAIT_STOP;
               end
            end
            S_WAIT_STOP: oe_d = 1'b0;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Protocol state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         ph_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ph_q    <= ph_d;
         oe_q    <= oe_d;
      end
   end

   // Register read mux
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         wb.adr_i == 5'h00: rdata = {6'b0, ctrl_q};
         wb.adr_i == 5'h04: rdata = status;
         wb.adr_i == 5'h08: rdata = tx_q;
         wb.adr_i == 5'h0C: rdata = rx_q;
         wb.adr_i == 5'h10: rdata = {1'b0, own_q};
         default:           rdata = '0;
      endcase
   end

   // Wishbone access and status updates; bus events win over bus-side clears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q       <= 1'b0;
         dat_o_q     <= '0;
         ctrl_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         own_q       <= SLAVE_ADDRESS;
         rx_valid_q  <= 1'b0;
         tx_empty_q  <= 1'b1;
         addressed_q <= 1'b0;
         rw_q        <= 1'b0;
         stk_q       <= '0;
      end else begin
         ack_q <= req;
         if (rd) dat_o_q <= rdata;
         if (wr) begin
            unique case (1'b1)
               wb.adr_i == 5'h00: ctrl_q <= wb.dat_i[1:0];
               wb.adr_i == 5'h04: stk_q <= stk_q & ~wb.dat_i[7:4];
               wb.adr_i == 5'h08: begin
                  tx_q       <= wb.dat_i;
                  tx_empty_q <= 1'b0;
               end
               wb.adr_i == 5'h10: own_q <= wb.dat_i[6:0];
               default: ;
            endcase
         end
         if (rx_rd) rx_valid_q <= 1'b0;
         if (ev_rx) begin
            rx_q       <= rx_byte;
            rx_valid_q <= 1'b1;
         end
         if (ev_load) begin
            tx_empty_q <= 1'b1;
            if (tx_empty_q && !tx_wr) stk_q[2] <= 1'b1;
         end
         if (ev_addr) begin
            addressed_q <= 1'b1;
            rw_q        <= rx_byte[0];
         end
         if (ev_stop) begin
            addressed_q <= 1'b0;
            stk_q[0]    <= 1'b1;
         end
         if (ev_ovr)   stk_q[1] <= 1'b1;
         if (ev_mnack) stk_q[3] <= 1'b1;
      end
   end

   assign wb.ack_o = ack_q;
   assign wb.dat_o = dat_o_q;

endmodule
